// File: rtl/arb_bus_mux.sv
// arb_bus_mux
//   Fixed-priority bus multiplexer with one register stage. The highest-indexed
//   source whose enable is set wins the bus; its word appears on bus_out one
//   clock later. Cycles with two or more enables are flagged as conflicts and
//   counted in a saturating counter with a sticky summary flag.
//
// Parameters
//   WIDTH      bus word width in bits (1..64)
//   NSRC       number of bus sources (2..64)
//   HOLD_LAST  1: bus_out/sel_idx hold when idle, 0: they return to zero
//   CNT_W      conflict counter width
//
// Ports
//   clk              system clock, rising edge
//   clr              asynchronous active-high reset
//   src_out          per-source drive enable, bit i requests source i
//   src_data         flattened source words, source i at [i*WIDTH +: WIDTH]
//   err_clr          synchronous clear of conflict_sticky and conflict_cnt
//   bus_out          registered bus word
//   bus_valid        bus_out was driven by a source at the last edge
//   sel_idx          registered index of the winning source
//   conflict         one-cycle pulse: >= 2 enables at the last edge
//   conflict_sticky  OR of all conflict pulses since the last clear
//   conflict_cnt     saturating count of conflicting edges
module arb_bus_mux #(
   parameter int WIDTH     = 32,
   parameter int NSRC      = 24,
   parameter int HOLD_LAST = 1,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [NSRC-1:0]          src_out,
   input  logic [NSRC*WIDTH-1:0]    src_data,
   input  logic                     err_clr,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_valid,
   output logic [$clog2(NSRC)-1:0]  sel_idx,
   output logic                     conflict,
   output logic                     conflict_sticky,
   output logic [CNT_W-1:0]         conflict_cnt
);

   localparam int IDX_W = $clog2(NSRC);

   logic             anyReq;
   logic             multiReq;
   logic [IDX_W-1:0] winIdx;
   logic [WIDTH-1:0] winData;

   // Ascending scan: a later (higher) set bit overwrites the winner, giving
   // highest-index priority. A set bit seen after any earlier one marks a
   // conflict, which is exactly popcount >= 2.
   always_comb begin
      anyReq   = 1'b0;
      multiReq = 1'b0;
      winIdx   = '0;
      winData  = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (src_out[i]) begin
            multiReq = multiReq | anyReq;
            anyReq   = 1'b1;
            winIdx   = IDX_W'(i);
            winData  = src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bus_out         <= '0;
         bus_valid       <= 1'b0;
         sel_idx         <= '0;
         conflict        <= 1'b0;
         conflict_sticky <= 1'b0;
         conflict_cnt    <= '0;
      end else begin
         bus_valid <= anyReq;
         conflict  <= multiReq;
         if (anyReq) begin
            bus_out <= winData;
            sel_idx <= winIdx;
         end else if (HOLD_LAST == 0) begin
            bus_out <= '0;
            sel_idx <= '0;
         end
         // Clear wins over a same-edge conflict; the pulse above is unaffected.
         if (err_clr) begin
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
         end else if (multiReq) begin
            conflict_sticky <= 1'b1;
            if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_arb_bus_mux.sv
module tb_arb_bus_mux;

   logic clk = 1'b0;
   logic clr;
   logic errClr;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // A: defaults (WIDTH=32, NSRC=24, HOLD_LAST=1, CNT_W=8)
   logic [23:0]      aOut;
   logic [24*32-1:0] aData;
   logic [31:0]      aBus;
   logic             aValid, aConf, aSticky;
   logic [4:0]       aSel;
   logic [7:0]       aCnt;

   // B: HOLD_LAST=0, CNT_W=2
   logic [23:0]      bOut;
   logic [24*32-1:0] bData;
   logic [31:0]      bBus;
   logic             bValid, bConf, bSticky;
   logic [4:0]       bSel;
   logic [1:0]       bCnt;

   // C: NSRC=2, WIDTH=8
   logic [1:0]       cOut;
   logic [15:0]      cData;
   logic [7:0]       cBus;
   logic             cValid, cConf, cSticky;
   logic [0:0]       cSel;
   logic [7:0]       cCnt;

   // D: NSRC=64, WIDTH=8
   logic [63:0]      dOut;
   logic [511:0]     dData;
   logic [7:0]       dBus;
   logic             dValid, dConf, dSticky;
   logic [5:0]       dSel;
   logic [7:0]       dCnt;

   arb_bus_mux #(.WIDTH(32), .NSRC(24), .HOLD_LAST(1), .CNT_W(8)) uA (
      .clk(clk), .clr(clr), .src_out(aOut), .src_data(aData), .err_clr(errClr),
      .bus_out(aBus), .bus_valid(aValid), .sel_idx(aSel), .conflict(aConf),
      .conflict_sticky(aSticky), .conflict_cnt(aCnt));

   arb_bus_mux #(.WIDTH(32), .NSRC(24), .HOLD_LAST(0), .CNT_W(2)) uB (
      .clk(clk), .clr(clr), .src_out(bOut), .src_data(bData), .err_clr(errClr),
      .bus_out(bBus), .bus_valid(bValid), .sel_idx(bSel), .conflict(bConf),
      .conflict_sticky(bSticky), .conflict_cnt(bCnt));

   arb_bus_mux #(.WIDTH(8), .NSRC(2), .HOLD_LAST(1), .CNT_W(8)) uC (
      .clk(clk), .clr(clr), .src_out(cOut), .src_data(cData), .err_clr(errClr),
      .bus_out(cBus), .bus_valid(cValid), .sel_idx(cSel), .conflict(cConf),
      .conflict_sticky(cSticky), .conflict_cnt(cCnt));

   arb_bus_mux #(.WIDTH(8), .NSRC(64), .HOLD_LAST(1), .CNT_W(8)) uD (
      .clk(clk), .clr(clr), .src_out(dOut), .src_data(dData), .err_clr(errClr),
      .bus_out(dBus), .bus_valid(dValid), .sel_idx(dSel), .conflict(dConf),
      .conflict_sticky(dSticky), .conflict_cnt(dCnt));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      aOut = 24'd1 << 5;
      aData[5*32 +: 32] = 32'h55AA1234;
      tick();
      tick();
      vecs++;
      if (aValid !== 1'b1 || aSel !== 5'd5) begin
         errs++;
         $display("FAIL pre_reset valid=%b sel=%0d required valid=1 sel=5", aValid, aSel);
      end
      // mid-cycle async assert, no edge in between
      #2 clr = 1'b1;
      #1;
      vecs++;
      if ({aBus, aValid, aSel, aConf, aSticky, aCnt} !== '0) begin
         errs++;
         $display("FAIL reset_async bus=%h valid=%b sel=%0d conf=%b sticky=%b cnt=%0d required all 0",
                  aBus, aValid, aSel, aConf, aSticky, aCnt);
      end
      #1 clr = 1'b0;
      tick();
      vecs++;
      if (aValid !== 1'b1 || aSel !== 5'd5 || aBus !== 32'h55AA1234) begin
         errs++;
         $display("FAIL reset_release valid=%b sel=%0d bus=%h required 1 5 55aa1234", aValid, aSel, aBus);
      end
      aOut = '0;
      tick();
   endtask

   task automatic test_single;
      aOut = 24'd1 << 3;
      bOut = 24'd1 << 3;
      aData[3*32 +: 32] = 32'hDEADBEEF;
      bData[3*32 +: 32] = 32'hDEADBEEF;
      tick();
      vecs++;
      if (aBus !== 32'hDEADBEEF || aValid !== 1'b1 || aSel !== 5'd3 || aConf !== 1'b0) begin
         errs++;
         $display("FAIL single_a bus=%h valid=%b sel=%0d conf=%b required deadbeef 1 3 0", aBus, aValid, aSel, aConf);
      end
      vecs++;
      if (bBus !== 32'hDEADBEEF || bValid !== 1'b1 || bSel !== 5'd3 || bConf !== 1'b0) begin
         errs++;
         $display("FAIL single_b bus=%h valid=%b sel=%0d conf=%b required deadbeef 1 3 0", bBus, bValid, bSel, bConf);
      end
      aOut = '0;
      bOut = '0;
      tick();
      vecs++;
      if (aBus !== 32'hDEADBEEF || aValid !== 1'b0 || aSel !== 5'd3) begin
         errs++;
         $display("FAIL idle_hold bus=%h valid=%b sel=%0d required deadbeef 0 3", aBus, aValid, aSel);
      end
      vecs++;
      if (bBus !== 32'h0 || bValid !== 1'b0 || bSel !== 5'd0) begin
         errs++;
         $display("FAIL idle_zero bus=%h valid=%b sel=%0d required 0 0 0", bBus, bValid, bSel);
      end
   endtask

   task automatic test_conflict;
      for (int i = 0; i < 24; i++) aData[i*32 +: 32] = 32'hFFFF0000 + i;
      aData[23*32 +: 32] = 32'h00000017;
      aOut = (24'd1 << 0) | (24'd1 << 16) | (24'd1 << 23);
      tick();
      vecs++;
      if (aBus !== 32'h17 || aSel !== 5'd23 || aConf !== 1'b1 || aSticky !== 1'b1 || aCnt !== 8'd1) begin
         errs++;
         $display("FAIL conflict bus=%h sel=%0d conf=%b sticky=%b cnt=%0d required 17 23 1 1 1",
                  aBus, aSel, aConf, aSticky, aCnt);
      end
      aOut = '0;
      tick();
      vecs++;
      if (aConf !== 1'b0 || aSticky !== 1'b1 || aCnt !== 8'd1) begin
         errs++;
         $display("FAIL conflict_after conf=%b sticky=%b cnt=%0d required 0 1 1", aConf, aSticky, aCnt);
      end
   endtask

   task automatic test_saturate;
      logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      bOut = (24'd1 << 1) | (24'd1 << 2);
      bData[2*32 +: 32] = 32'h22;
      for (int k = 0; k < 5; k++) begin
         tick();
         vecs++;
         if (bCnt !== exp[k] || bConf !== 1'b1 || bBus !== 32'h22) begin
            errs++;
            $display("FAIL saturate[%0d] cnt=%0d conf=%b bus=%h required %0d 1 22", k, bCnt, bConf, bBus, exp[k]);
         end
      end
      bOut = '0;
      tick();
      vecs++;
      if (bConf !== 1'b0 || bCnt !== 2'd3 || bSticky !== 1'b1) begin
         errs++;
         $display("FAIL saturate_idle conf=%b cnt=%0d sticky=%b required 0 3 1", bConf, bCnt, bSticky);
      end
   endtask

   task automatic test_clr_collision;
      aData[9*32 +: 32] = 32'h99999999;
      aOut = (24'd1 << 4) | (24'd1 << 9);
      errClr = 1'b1;
      tick();
      vecs++;
      if (aConf !== 1'b1 || aSticky !== 1'b0 || aCnt !== 8'd0 ||
          aBus !== 32'h99999999 || aValid !== 1'b1 || aSel !== 5'd9) begin
         errs++;
         $display("FAIL clr_collision conf=%b sticky=%b cnt=%0d bus=%h valid=%b sel=%0d required 1 0 0 99999999 1 9",
                  aConf, aSticky, aCnt, aBus, aValid, aSel);
      end
      errClr = 1'b0;
      aOut = '0;
      tick();
      vecs++;
      if (aConf !== 1'b0 || aSticky !== 1'b0 || aCnt !== 8'd0 || aBus !== 32'h99999999) begin
         errs++;
         $display("FAIL clr_after conf=%b sticky=%b cnt=%0d bus=%h required 0 0 0 99999999", aConf, aSticky, aCnt, aBus);
      end
   endtask

   task automatic test_back_to_back;
      aOut = 24'd1 << 7;
      for (int k = 0; k < 4; k++) begin
         aData[7*32 +: 32] = 32'h1000 + k;
         aData[2*32 +: 32] = $urandom;   // disabled source, must not matter
         aData[20*32 +: 32] = $urandom;
         tick();
         vecs++;
         if (aBus !== 32'h1000 + k || aValid !== 1'b1 || aSel !== 5'd7 || aConf !== 1'b0) begin
            errs++;
            $display("FAIL back_to_back[%0d] bus=%h valid=%b sel=%0d conf=%b required %h 1 7 0",
                     k, aBus, aValid, aSel, aConf, 32'h1000 + k);
         end
      end
      aOut = '0;
      tick();
   endtask

   task automatic test_walk;
      for (int i = 0; i < 2; i++) begin
         cData = 16'hA5A5;
         cData[i*8 +: 8] = 8'(i);
         cOut = 2'd1 << i;
         tick();
         vecs++;
         if (cBus !== 8'(i) || cSel !== 1'(i) || cValid !== 1'b1 || cConf !== 1'b0) begin
            errs++;
            $display("FAIL walk2[%0d] bus=%0d sel=%0d valid=%b conf=%b required %0d %0d 1 0",
                     i, cBus, cSel, cValid, cConf, i, i);
         end
      end
      cOut = '0;
      for (int i = 0; i < 64; i++) begin
         for (int j = 0; j < 16; j++) dData[j*32 +: 32] = $urandom;
         dData[i*8 +: 8] = 8'(i);
         dOut = 64'd1 << i;
         tick();
         vecs++;
         if (dBus !== 8'(i) || dSel !== 6'(i) || dValid !== 1'b1 || dConf !== 1'b0) begin
            errs++;
            $display("FAIL walk64[%0d] bus=%0d sel=%0d valid=%b conf=%b required %0d %0d 1 0",
                     i, dBus, dSel, dValid, dConf, i, i);
         end
      end
      dOut = '0;
      tick();
      vecs++;
      if (cCnt !== 8'd0 || cSticky !== 1'b0 || dCnt !== 8'd0 || dSticky !== 1'b0) begin
         errs++;
         $display("FAIL walk_noconf c_cnt=%0d c_sticky=%b d_cnt=%0d d_sticky=%b required 0 0 0 0",
                  cCnt, cSticky, dCnt, dSticky);
      end
   endtask

   initial begin
      clr = 1'b1;
      errClr = 1'b0;
      aOut = '0; aData = '0;
      bOut = '0; bData = '0;
      cOut = '0; cData = '0;
      dOut = '0; dData = '0;
      tick();
      tick();
      clr = 1'b0;
      test_reset();
      test_single();
      test_conflict();
      test_saturate();
      test_clr_collision();
      test_back_to_back();
      test_walk();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/arb_bus_mux.md
ARB_BUS_MUX -- requirements
Module: arb_bus_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning bus word width in bits (legal 1..64).
REQ-002 The block SHALL have parameter NSRC, default 24, meaning number of bus sources (legal 2..64).
REQ-003 The block SHALL have parameter HOLD_LAST, default 1, meaning 1 = bus holds last driven word when idle, 0 = bus returns to zero when idle.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning width of the conflict counter.
REQ-005 The block SHALL have port clk, input, 1, meaning single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port clr, input, 1, meaning reset, asynchronous and active-high.
REQ-007 The block SHALL have port src_out, input, NSRC, meaning per-source bus-drive enable; bit i requests source i onto the bus.
REQ-008 The block SHALL have port src_data, input, NSRC*WIDTH, meaning flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port err_clr, input, 1, meaning synchronous clear of sticky error state and conflict counter.
REQ-010 The block SHALL have port bus_out, output, WIDTH, meaning registered bus word.
REQ-011 The block SHALL have port bus_valid, output, 1, meaning bus_out was driven by a source in the previous cycle.
REQ-012 The block SHALL have port sel_idx, output, clog2(NSRC), meaning registered index of the winning source.
REQ-013 The block SHALL have port conflict, output, 1, meaning registered one-cycle pulse: two or more enables were asserted in the previous cycle.
REQ-014 The block SHALL have port conflict_sticky, output, 1, meaning latched OR of all conflict pulses since the last clear.
REQ-015 The block SHALL have port conflict_cnt, output, CNT_W, meaning saturating count of conflicting cycles.

Function
REQ-016 Arbitration SHALL be fixed priority: the highest-indexed asserted src_out bit wins.
REQ-017 Latency SHALL be exactly one clock: the winner's src_data sampled at edge N appears on bus_out after edge N, with bus_valid=1 and sel_idx=winner index.
REQ-018 With no src_out bit set at an edge, bus_valid SHALL be 0 next cycle; bus_out and sel_idx SHALL hold their previous values if HOLD_LAST=1, else both SHALL be 0.
REQ-019 Popcount(src_out) >= 2 at an edge SHALL set conflict=1 for the following cycle only; the winner is still driven per REQ-016.
REQ-020 Each conflicting edge SHALL set conflict_sticky and increment conflict_cnt by one; conflict_cnt SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-021 err_clr=1 at an edge SHALL clear conflict_sticky and conflict_cnt to 0; if a conflict occurs at the same edge, clear takes precedence for the sticky flag and counter, while the conflict pulse is still generated.
REQ-022 err_clr SHALL NOT affect bus_out, bus_valid or sel_idx.
REQ-023 A source enable held for K consecutive edges SHALL give K consecutive valid cycles with each cycle's word tracking that edge's src_data (no input latching beyond one register stage).
REQ-024 src_data of non-winning sources SHALL have no effect on any output.

Reset
REQ-025 While clr=1, bus_out, sel_idx, conflict_cnt SHALL be 0 and bus_valid, conflict, conflict_sticky SHALL be 0, immediately and without a clock edge.
REQ-026 Deassertion of clr SHALL resume normal sampling at the first subsequent rising edge; a transfer in flight when clr asserts SHALL be discarded.

Verification
REQ-027 Bench: clr pulse mid-cycle with src_out[5]=1 -> all outputs 0 immediately, no edge needed; after release, first edge yields bus_valid=1, sel_idx=5.
REQ-028 Bench: src_out=1<<3, src_data word3=0xDEADBEEF for one edge -> next cycle bus_out=0xDEADBEEF, bus_valid=1, sel_idx=3, conflict=0; following idle cycle bus_valid=0, bus_out=0xDEADBEEF (HOLD_LAST=1) or 0 (HOLD_LAST=0).
REQ-029 Bench: src_out bits 0, 16, 23 set, word23=0x00000017 -> bus_out=0x00000017, sel_idx=23, conflict=1 for one cycle, conflict_sticky=1, conflict_cnt=1.
REQ-030 Bench: CNT_W=2, five consecutive conflicting edges -> conflict_cnt sequence 1,2,3,3,3; conflict high all five cycles.
REQ-031 Bench: conflict and err_clr at same edge -> conflict=1 next cycle, conflict_sticky=0, conflict_cnt=0, bus_out unaffected.
REQ-032 Bench: NSRC=2 and NSRC=64 builds, walking single-bit enable across all sources with data=index -> bus_out=index, sel_idx=index each cycle, zero conflicts.
